addsub_seq: RTL and testbench

//  Parametrised multi-cycle signed adder/subtractor. Successor to the 32-bit

---
 rtl/alu_pkg.sv | 12 +
 rtl/addsub_chunk.sv | 15 +
 rtl/addsub_seq.sv | 113 +++++++++++
 tb/tb_addsub_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding and the add/sub sequencer state type.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit adder slice with carry in/out; the sequencer reuses
// this one instance every RUN cycle.
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle signed adder/subtractor: CHUNK bits per cycle, LSB first, with
// a registered carry chain, status flags and a start/busy/done handshake.
module addsub_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic [WIDTH-1:0] rd,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  state_e           state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, rd_q;
  logic             cin_q, carry_q, ovf_q, zero_q, busy_q, done_q;

  logic [CHUNK-1:0] a_chunk [N];
  logic [CHUNK-1:0] b_chunk [N];
  logic [CHUNK-1:0] a_cur, b_cur, s_cur;
  logic             cout_cur;
  logic [WIDTH-1:0] sum_d;

  // sum_d is the internal result with the current chunk merged in, so the
  // final edge can publish the complete sum without waiting another cycle.
  for (genvar gi = 0; gi < N; gi++) begin : g_chunk
    assign a_chunk[gi] = a_q[gi*CHUNK +: CHUNK];
    assign b_chunk[gi] = b_q[gi*CHUNK +: CHUNK];
    assign sum_d[gi*CHUNK +: CHUNK] =
      (idx_q == IW'(gi)) ? s_cur : sum_q[gi*CHUNK +: CHUNK];
  end

  assign a_cur = a_chunk[idx_q];
  assign b_cur = b_chunk[idx_q];

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_cur),
    .b    (b_cur),
    .cin  (cin_q),
    .s    (s_cur),
    .cout (cout_cur)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      rd_q    <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= rs;
            b_q     <= (op == OP_ADD) ? rt : ~rt;
            cin_q   <= (op == OP_SUB);
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          sum_q <= sum_d;
          cin_q <= cout_cur;
          if (idx_q == IDX_LAST) begin
            idx_q   <= '0;
            rd_q    <= sum_d;
            carry_q <= cout_cur;
            ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
            zero_q  <= (sum_d == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd       = rd_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Scoreboard bench for addsub_seq: three configurations (32/8, 32/32, 16/4),
// directed vectors pushed to per-DUT queues and checked by done-driven monitors.
module tb_addsub_seq;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] rd;
    logic        c;
    logic        v;
    logic        z;
    int          due;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic        op = 1'b0;
  logic [31:0] rs = '0, rt = '0;

  logic [31:0] rd0, rd1;
  logic [15:0] rd2;
  logic        c0, v0, z0, b0, d0;
  logic        c1, v1, z1, b1, d1;
  logic        c2, v2, z2, b2, d2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc;

  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_seq #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .op(op), .rs(rs), .rt(rt),
    .rd(rd0), .carry(c0), .overflow(v0), .zero(z0), .busy(b0), .done(d0));

  addsub_seq #(.WIDTH(32), .CHUNK(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op), .rs(rs), .rt(rt),
    .rd(rd1), .carry(c1), .overflow(v1), .zero(z1), .busy(b1), .done(d1));

  addsub_seq #(.WIDTH(16), .CHUNK(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op(op), .rs(rs[15:0]), .rt(rt[15:0]),
    .rd(rd2), .carry(c2), .overflow(v2), .zero(z2), .busy(b2), .done(d2));

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [31:0] r,
                              input logic c, input logic v, input logic z);
    exp_t e;
    e.tag = tag; e.rd = r; e.c = c; e.v = v; e.z = z; e.due = 0;
    return e;
  endfunction

  task automatic check(input exp_t e, input logic [31:0] r, input logic c,
                       input logic v, input logic z);
    cmp({e.tag, ".rd"}, r, e.rd);
    cmp({e.tag, ".carry"}, {31'd0, c}, {31'd0, e.c});
    cmp({e.tag, ".overflow"}, {31'd0, v}, {31'd0, e.v});
    cmp({e.tag, ".zero"}, {31'd0, z}, {31'd0, e.z});
    cmp({e.tag, ".done_cycle"}, cyc, e.due);
    $display("txn %s: rd=%h carry=%b ovf=%b zero=%b done@%0d", e.tag, r, c, v, z, cyc);
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got done=1 with no pending op, expected done=0", name);
  endtask

  always @(negedge clk) if (d0 === 1'b1) begin
    if (q0.size() == 0) unexpected("dut0.spurious_done");
    else check(q0.pop_front(), rd0, c0, v0, z0);
  end
  always @(negedge clk) if (d1 === 1'b1) begin
    if (q1.size() == 0) unexpected("dut1.spurious_done");
    else check(q1.pop_front(), rd1, c1, v1, z1);
  end
  always @(negedge clk) if (d2 === 1'b1) begin
    if (q2.size() == 0) unexpected("dut2.spurious_done");
    else check(q2.pop_front(), {16'h0, rd2}, c2, v2, z2);
  end

  task automatic set_start(input int d, input logic v);
    case (d)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic push_q(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Drives one start pulse; acc_o is the cycle count just after the accept edge.
  task automatic issue(input int d, input logic o, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input exp_t e, input int lat, output int acc_o);
    @(negedge clk);
    op = o; rs = a; rt = b;
    set_start(d, 1'b1);
    @(posedge clk); #1;
    acc_o = cyc;
    if (push) begin
      e.due = acc_o + lat;
      push_q(d, e);
    end
    @(negedge clk);
    set_start(d, 1'b0);
  endtask

  task automatic drain(input int d);
    for (int i = 0; i < 40 && qsize(d) != 0; i++) begin
      @(negedge clk); #1;
    end
    cmp($sformatf("dut%0d.pending_after_timeout", d), qsize(d), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    cmp("reset.rd", rd0, 32'h0);
    cmp("reset.flags", {28'd0, c0, v0, z0, d0}, 32'h0);
    cmp("reset.busy", {29'd0, b0, b1, b2}, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Equal-operand subtract, zero result, 4-cycle latency
    issue(0, OP_SUB, 32'h1C71C71C, 32'h1C71C71C, 1, mk("sub_equal", 32'h0, 1, 0, 1), 4, acc);
    drain(0);
    issue(0, OP_SUB, 32'h00000001, 32'h80000000, 1, mk("sub_minneg", 32'h80000001, 0, 1, 0), 4, acc);
    drain(0);
    issue(0, OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1, mk("add_ovf", 32'h80000000, 0, 1, 0), 4, acc);
    drain(0);
    issue(0, OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1, mk("add_wrap", 32'h0, 1, 0, 1), 4, acc);
    drain(0);

    // Handshake: start while busy ignored, start in done cycle accepted
    issue(0, OP_ADD, 32'h00001234, 32'h00000010, 1, mk("hs_first", 32'h00001244, 0, 0, 0), 4, acc);
    op = OP_SUB; rs = 32'hDEADBEEF; rt = 32'h00000001; start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    while (cyc < acc + 4) @(negedge clk);
    #1;
    op = OP_SUB; rs = 32'h00000010; rt = 32'h00000020; start0 = 1'b1;
    @(posedge clk); #1;
    begin
      exp_t e;
      e = mk("hs_b2b", 32'hFFFFFFF0, 0, 0, 0);
      e.due = cyc + 4;
      q0.push_back(e);
    end
    @(negedge clk) start0 = 1'b0;
    drain(0);

    // Reset mid-run aborts with no done pulse
    issue(0, OP_SUB, 32'h00000005, 32'h00000003, 0, mk("aborted", 32'h0, 0, 0, 0), 4, acc);
    @(negedge clk) rst_n = 1'b0;
    #1;
    cmp("midreset.rd", rd0, 32'h0);
    cmp("midreset.flags", {28'd0, c0, v0, z0, d0}, 32'h0);
    cmp("midreset.busy", {31'd0, b0}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(0, OP_ADD, 32'h12345678, 32'h11111111, 1, mk("post_reset", 32'h23456789, 0, 0, 0), 4, acc);
    drain(0);

    // Single-cycle and narrow configurations
    issue(1, OP_ADD, 32'h00000005, 32'hFFFFFFF9, 1, mk("c32_add", 32'hFFFFFFFE, 0, 0, 0), 1, acc);
    drain(1);
    issue(2, OP_SUB, 32'h00008000, 32'h00000001, 1, mk("w16_sub", 32'h00007FFF, 1, 1, 0), 4, acc);
    drain(2);
    issue(2, OP_ADD, 32'h0000FFFF, 32'h00000001, 1, mk("w16_wrap", 32'h00000000, 1, 0, 1), 4, acc);
    drain(2);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
